// File: rtl/snn_bram_responder.sv
// Word-addressed parameter/state memory shared by the SNN core's BRAM port and a host
// request/acknowledge port, with a decoded shadow of the FLAGS word and a done interrupt.
module snn_bram_responder #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTES_PER_WORD = 4,
    parameter int READ_LATENCY   = 2,
    parameter int FLAGS_ADDR     = 352
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     core_addr,
    input  logic                      core_en,
    input  logic [BYTES_PER_WORD-1:0] core_we,
    input  logic [DATA_WIDTH-1:0]     core_din,
    output logic [DATA_WIDTH-1:0]     core_dout,
    input  logic                      core_rst,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [ADDR_WIDTH-1:0]     host_addr,
    input  logic [DATA_WIDTH-1:0]     host_wdata,
    output logic                      host_ack,
    output logic [DATA_WIDTH-1:0]     host_rdata,
    output logic                      flag_en,
    output logic                      flag_done,
    output logic                      flag_rst,
    output logic                      irq_done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [ADDR_WIDTH-1:0] FLAGS_A = ADDR_WIDTH'(FLAGS_ADDR);

    typedef enum logic [1:0] {IDLE, WACK, RWAIT, DONE} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  grant;
    logic                  host_wr;
    logic                  host_rd;

    logic [DATA_WIDTH-1:0] core_dat_p [PW];
    logic [DATA_WIDTH-1:0] host_dat_p [PW];
    logic [PW-1:0]         core_vld_p;
    logic [PW-1:0]         host_vld_p;
    logic                  core_fin;
    logic                  host_fin;
    logic [DATA_WIDTH-1:0] core_src;
    logic [DATA_WIDTH-1:0] host_src;

    logic [2:0]            flags_sh;
    logic [2:0]            flags_new;

    // The core owns the single physical port whenever it is enabled.
    assign grant   = !core_en && host_req && (state == IDLE);
    assign host_wr = grant && host_we;
    assign host_rd = grant && !host_we;
    assign rd_word = mem[core_en ? core_addr : host_addr];

    // Stage p0: storage access, read-first against the write committed at this edge
    always_ff @(posedge clk) begin
        if (core_en) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (core_we[i]) mem[core_addr][8*i +: 8] <= core_din[8*i +: 8];
            end
        end else if (host_wr) begin
            mem[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        core_dat_p[0] <= rd_word;
        host_dat_p[0] <= rd_word;
        for (int i = 1; i < PW; i++) begin
            core_dat_p[i] <= core_dat_p[i-1];
            host_dat_p[i] <= host_dat_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_vld_p <= '0;
            host_vld_p <= '0;
        end else begin
            core_vld_p[0] <= core_en;
            host_vld_p[0] <= host_rd;
            for (int i = 1; i < PW; i++) begin
                core_vld_p[i] <= core_vld_p[i-1];
                host_vld_p[i] <= host_vld_p[i-1];
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign core_fin = core_en;
            assign core_src = rd_word;
            assign host_fin = host_rd;
            assign host_src = rd_word;
        end else begin : g_latn
            assign core_fin = core_vld_p[PW-1];
            assign core_src = core_dat_p[PW-1];
            assign host_fin = host_vld_p[PW-1];
            assign host_src = host_dat_p[PW-1];
        end
    endgenerate

    // Final stage: output registers; core_rst wins over arriving read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_dout <= '0;
        end else if (core_rst) begin
            core_dout <= '0;
        end else if (core_fin) begin
            core_dout <= core_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_wr) begin
                        host_ack <= 1'b1;
                        state    <= WACK;
                    end else if (host_rd) begin
                        state <= RWAIT;
                    end
                end
                WACK:    state <= DONE;
                RWAIT:   state <= RWAIT;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // The ack cycle of a read reuses WACK so both paths share the DONE dead cycle.
            if (host_fin) begin
                host_rdata <= host_src;
                host_ack   <= 1'b1;
                state      <= WACK;
            end
        end
    end

    always_comb begin
        flags_new = flags_sh;
        if (core_en) begin
            if (core_addr == FLAGS_A && core_we[0]) flags_new = core_din[2:0];
        end else if (host_wr && host_addr == FLAGS_A) begin
            flags_new = host_wdata[2:0];
        end
    end

    // Flags: shadow follows the write edge, decoded outputs one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_sh  <= '0;
            flag_en   <= 1'b0;
            flag_done <= 1'b0;
            flag_rst  <= 1'b0;
            irq_done  <= 1'b0;
        end else begin
            flags_sh  <= flags_new;
            flag_en   <= flags_sh[0];
            flag_done <= flags_sh[1];
            flag_rst  <= flags_sh[2];
            irq_done  <= flags_sh[1] && !flag_done;
        end
    end

endmodule
